// File: rtl/polar_encoder.sv
// Serial-in/serial-out polar encoder: x = u * F^{(x)n}, F = [[1,0],[1,1]], natural order.
// Bits load into an in-place buffer, one butterfly stage runs per cycle, then the codeword streams out.
module polar_encoder #(
  parameter int N_MAX     = 512,
  parameter int LOG_N_MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] n_sel,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  localparam int SW = $clog2(LOG_N_MAX + 1);

  // Handshakes: a bit moves on a rising edge where valid & ready are both high;
  // out_bit/out_last hold while out_valid is high and out_ready is low.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ENCODE, S_OUT} state_e;

  state_e                 state_q, state_d;
  logic [N_MAX-1:0]       buf_q, buf_d;
  logic [LOG_N_MAX-1:0]   idx_q, idx_d;
  logic [LOG_N_MAX-1:0]   last_q, last_d;   // N-1 of the current frame
  logic [SW-1:0]          stage_q, stage_d;
  logic [SW-1:0]          l_q, l_d;
  logic                   done_q, done_d;

  logic [SW-1:0]          l_new;
  logic [LOG_N_MAX-1:0]   last_new;
  logic                   at_last;

  // n_sel 0/1/2 selects the three largest powers of two up to N_MAX.
  assign l_new    = SW'(LOG_N_MAX - 2) + SW'(n_sel);
  assign last_new = LOG_N_MAX'((32'd1 << l_new) - 32'd1);
  assign at_last  = (idx_q == last_q);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    last_d  = last_q;
    stage_d = stage_q;
    l_d     = l_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && (n_sel != 2'd3)) begin
          l_d     = l_new;
          last_d  = last_new;
          buf_d   = '0;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          buf_d[idx_q] = in_bit;
          if (at_last) begin
            idx_d   = '0;
            stage_d = '0;
            state_d = S_ENCODE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_ENCODE: begin
        // Upper half of each 2d-block absorbs its partner; all reads see pre-stage values.
        for (int i = 0; i < N_MAX; i++) begin
          for (int s = 0; s < LOG_N_MAX; s++) begin
            if ((32'(stage_q) == s) && (((i >> s) & 1) == 0) && (i <= 32'(last_q))) begin
              buf_d[i] = buf_q[i] ^ buf_q[i | (1 << s)];
            end
          end
        end
        if (stage_q == (l_q - 1'b1)) begin
          idx_d   = '0;
          state_d = S_OUT;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (at_last) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      stage_q <= '0;
      l_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      stage_q <= stage_d;
      l_q     <= l_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign out_bit   = out_valid & buf_q[idx_q];
  assign out_last  = out_valid & at_last;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_polar_encoder.sv
// Scoreboard bench for polar_encoder: directed codewords, involution round trip,
// stalls, ignored starts, mid-frame reset and back-to-back frames.
module tb_polar_encoder;
  localparam int N_MAX = 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] n_sel = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_bit, out_last, busy, done;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];          // {last, bit}
  logic [N_MAX-1:0] cap_vec = '0;
  int cap_n = 0;
  bit rand_ready = 0;
  bit glitch_en = 0;
  bit stall_prev = 0;
  bit exp_done = 0;
  logic [1:0] held = '0;

  polar_encoder #(.N_MAX(N_MAX), .LOG_N_MAX(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_sel(n_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [N_MAX-1:0] polar_model(input logic [N_MAX-1:0] u, input int n);
    logic [N_MAX-1:0] x;
    logic acc;
    x = '0;
    // x[j] is the XOR of u[i] over every i whose bits cover j
    for (int j = 0; j < n; j++) begin
      acc = 1'b0;
      for (int i = 0; i < n; i++) if ((i & j) == j) acc ^= u[i];
      x[j] = acc;
    end
    return x;
  endfunction

  // driver processes
  always begin
    @(posedge clk); #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always begin
    @(posedge clk); #1;
    if (glitch_en) begin
      if (busy) begin
        start = 1'($urandom_range(0, 1));
        n_sel = 2'd2;
      end else begin
        start = 1'b0;
      end
    end
  end

  task automatic push_x(input logic [N_MAX-1:0] x, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back({(j == n - 1) ? 1'b1 : 1'b0, x[j]});
  endtask

  task automatic do_start(input int nsel);
    start = 1'b1;
    n_sel = 2'(nsel);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bits(input int n, input logic [N_MAX-1:0] u, input bit gaps);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 4 * n + 100) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_bit = u[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    in_bit = 1'b0;
    check("load_accept_count", idx, n);
  endtask

  task automatic check_latency(input int l);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 40);
    check("first_out_latency", k, l + 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (k < 3000) begin
      @(negedge clk);
      k++;
      if (done) break;
    end
    check("done_seen", done, 1);
  endtask

  task automatic run_frame(input int nsel, input logic [N_MAX-1:0] u, input logic [N_MAX-1:0] x,
                           input bit gaps, input bit lat, input bit glitch);
    int n = 128 << nsel;
    push_x(x, n);
    cap_n = 0;
    do_start(nsel);
    glitch_en = glitch;
    send_bits(n, u, gaps);
    if (lat) check_latency(7 + nsel);
    wait_done();
    @(posedge clk); #1;
    glitch_en = 0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst_n) begin
      stall_prev = 0;
      exp_done = 0;
    end else begin
      if (done || exp_done) check("done_pulse", done, exp_done);
      exp_done = 0;
      if (out_valid) begin
        if (stall_prev) check("stall_hold", {out_last, out_bit}, held);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("codeword_last_bit", {out_last, out_bit}, e);
            if (e[1]) exp_done = 1;
          end
          if (cap_n < N_MAX) cap_vec[cap_n] = out_bit;
          cap_n++;
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          held = {out_last, out_bit};
        end
      end else begin
        stall_prev = 0;
      end
    end
  end

  // main stimulus
  initial begin
    logic [N_MAX-1:0] u, x, ones128, u_r, c, x5;
    ones128 = '0;
    ones128[127:0] = '1;
    x5 = '0;
    x5[0] = 1'b1; x5[1] = 1'b1; x5[4] = 1'b1; x5[5] = 1'b1;

    repeat (3) @(posedge clk); #1;
    check("reset_outputs", {in_ready, out_valid, out_bit, out_last, busy, done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // u[127]=1, N=128 -> all ones
    u = '0; u[127] = 1'b1;
    run_frame(0, u, ones128, 0, 1, 0);

    // unit vectors at N=512
    u = '0; u[0] = 1'b1; x = '0; x[0] = 1'b1;
    run_frame(2, u, x, 0, 1, 0);
    u = '0; u[1] = 1'b1; x = '0; x[0] = 1'b1; x[1] = 1'b1;
    run_frame(2, u, x, 0, 0, 0);
    u = '0; u[5] = 1'b1;
    run_frame(2, u, x5, 0, 0, 0);

    // reserved length is ignored
    start = 1'b1; n_sel = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("nsel3_ignored", {busy, in_ready}, 0);
      @(posedge clk); #1;
    end

    // random N=256 with stalls, then feed the codeword back
    rand_ready = 1;
    u_r = '0;
    for (int i = 0; i < 256; i++) u_r[i] = 1'($urandom_range(0, 1));
    run_frame(1, u_r, polar_model(u_r, 256), 1, 0, 0);
    check("capture_count", cap_n, 256);
    c = cap_vec;
    run_frame(1, c, u_r, 1, 0, 0);
    rand_ready = 0;

    // starts pulsed during LOAD/ENCODE/OUT of a 128 frame
    u = '0; u[127] = 1'b1;
    run_frame(0, u, ones128, 0, 0, 1);
    check("idle_after_glitch", {busy, in_ready}, 0);

    // reset during stage 3 of a 512 frame
    u = '0;
    for (int i = 0; i < 512; i++) u[i] = 1'($urandom_range(0, 1));
    do_start(2);
    send_bits(512, u, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("reset_mid_encode", {in_ready, out_valid, out_bit, out_last, busy, done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    u = '0; u[127] = 1'b1;
    run_frame(0, u, ones128, 0, 0, 0);

    // back-to-back: second start in the done cycle
    push_x(ones128, 128);
    push_x(x5, 256);
    do_start(0);
    u = '0; u[127] = 1'b1;
    send_bits(128, u, 0);
    wait_done();
    start = 1'b1; n_sel = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_in_ready", in_ready, 1);
    u = '0; u[5] = 1'b1;
    send_bits(256, u, 0);
    wait_done();
    @(posedge clk); #1;

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/polar_encoder.md
Name: polar_encoder

Overview:
- Serial-in, serial-out polar encoder computing x = u·F^{⊗n}, with F = [[1,0],[1,1]], natural order (no bit-reversal), over GF(2).
- Transmit-side counterpart of the SC decoder datapath, and the reference codeword source for decoder test generation.
- Takes a full u vector, frozen positions already zeroed by the caller.
- Runs one butterfly stage per cycle in place, then streams the codeword out under valid/ready.

Parameters:
- N_MAX, 512, largest supported code length; buffer depth.
- LOG_N_MAX, 9, log2(N_MAX); stage and index counter widths derive from it.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a frame; honoured only in IDLE.
- n_sel  in  2  code length, sampled with start: 0→128, 1→256, 2→512, 3→reserved.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  encoder accepts an input bit.
- in_bit  in  1  u bit. u[0] first, u[N-1] last.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  sink accepts out_bit.
- out_bit  out  1  codeword bit. x[0] first.
- out_last  out  1  high with x[N-1].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the cycle after x[N-1] is accepted.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, buffer cleared to 0. Reset is legal in any state; the frame is abandoned and nothing is flushed.
- States: IDLE → LOAD → ENCODE → OUT → IDLE.
- IDLE:
  - start=1 with n_sel≠3: latch N and L = log2(N) (7/8/9), clear the buffer, clear idx, go to LOAD.
  - start=1 with n_sel=3: ignored; the block stays in IDLE and busy stays 0.
- LOAD:
  - in_ready=1 from the cycle after start.
  - Each cycle with in_valid & in_ready: buf[idx] ← in_bit, idx++.
  - When bit N-1 is accepted: in_ready drops the next cycle, idx ← 0, stage ← 0, go to ENCODE.
  - in_valid gaps are allowed; the FSM simply waits.
- ENCODE:
  - Exactly L cycles, stage s = 0..L-1, d = 2^s.
  - For every i < N with (i & d) == 0: buf[i] ← buf[i] ^ buf[i+d], all i updated in parallel from pre-stage values.
  - Entries at or above N are never read or written.
  - After stage L-1, go to OUT.
- OUT:
  - out_valid=1, out_bit=buf[idx], out_last=(idx==N-1).
  - On out_valid & out_ready: idx++.
  - While out_ready=0, out_bit and out_last hold stable.
  - When the last bit is accepted: done=1 for one cycle, out_valid=0, go to IDLE.
- Latency: last input bit accepted in cycle t → out_valid first high in cycle t+L+1. Full-throughput frame time is N + L + N + 1 cycles.
- start in any state other than IDLE is ignored, and n_sel is not re-sampled.
- A new start in the same cycle done is high is accepted, since the FSM is already in IDLE.
- in_valid while in_ready=0 has no effect.
- Encoding is an involution: G·G = I over GF(2).

Test Plan:
- n_sel=0, u[127]=1, all other bits 0 → x is all ones (128 bits). out_last only on x[127]. done 1 cycle later. out_valid first high 8 cycles after the last input accepted.
- n_sel=2, u[0]=1 only → x[0]=1, x[1..511]=0. Then u[1]=1 only → x[0]=x[1]=1, rest 0. General row check: x[j] = 1 iff (j & ~i)==0 for u = e_i; check i=5 (x[0],x[1],x[4],x[5]=1).
- n_sel=1, random u; feed the captured x back as a new frame → output equals the original u (involution). Randomly toggle in_valid and out_ready at 50% duty → data unchanged, out_bit stable while stalled, no bit lost or duplicated.
- Pulse start during LOAD, ENCODE and OUT with n_sel=2 during an n_sel=0 frame → frame length stays 128, no state change. start with n_sel=3 in IDLE → busy stays 0, in_ready stays 0.
- Deassert rst_n mid-ENCODE (stage 3 of a 512 frame) → all outputs 0 immediately. After release, a fresh 128-bit frame with u[127]=1 yields all ones, with no residue from the aborted frame.
- Back-to-back frames: start asserted in the done cycle → second frame LOADs without an idle gap and both codewords are correct.
